// File: rtl/quad_core_pkg.sv
// Shared constants, core state encoding and operand generators for the quad-core 8x8 multiplier.
package quad_core_pkg;

    localparam int unsigned DATA_W        = 12;
    localparam int unsigned DIM           = 8;
    localparam int unsigned NUM_CORES     = 4;
    localparam int unsigned ROWS_PER_CORE = 2;
    localparam int unsigned MAC_CYCLES    = 8;
    localparam int unsigned BANK_DEPTH    = ROWS_PER_CORE * DIM;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE,
        DONE
    } core_state_e;

    // A[r][k] = 8r + k
    function automatic logic [DATA_W-1:0] op_a(input logic [2:0] r, input logic [2:0] k);
        return {6'd0, r, 3'd0} + {9'd0, k};
    endfunction

    // B[k][c] = k + c
    function automatic logic [DATA_W-1:0] op_b(input logic [2:0] k, input logic [2:0] c);
        return {9'd0, k} + {9'd0, c};
    endfunction

endpackage

// File: rtl/matmul_core.sv
// One compute core: produces two consecutive rows of C into a private 16-entry result bank.
module matmul_core
    import quad_core_pkg::*;
#(
    parameter int unsigned BASE_ROW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              done_o
);

    core_state_e       state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [3:0]        elem_q, elem_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              done_q;
    logic [DATA_W-1:0] bank_q [BANK_DEPTH];
    logic              bank_we;
    logic [2:0]        row;
    logic [2:0]        col;
    logic [DATA_W-1:0] prod;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        elem_d  = elem_q;
        acc_d   = acc_q;
        bank_we = 1'b0;
        // elem_q[3] picks the second owned row; low bits are the column
        row     = 3'(BASE_ROW) + {2'b00, elem_q[3]};
        col     = elem_q[2:0];
        prod    = op_a(row, k_q) * op_b(k_q, col);

        unique case (state_q)
            IDLE: begin
                state_d = MAC;
                k_d     = 3'd0;
                elem_d  = 4'd0;
                acc_d   = '0;
            end
            MAC: begin
                acc_d = acc_q + prod;
                k_d   = k_q + 3'd1;
                if (k_q == 3'(MAC_CYCLES - 1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bank_we = 1'b1;
                acc_d   = '0;
                k_d     = 3'd0;
                if (elem_q == 4'(BANK_DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    elem_d  = elem_q + 4'd1;
                    state_d = MAC;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            elem_q  <= 4'd0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(BANK_DEPTH); i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            elem_q  <= elem_d;
            acc_q   <= acc_d;
            done_q  <= (state_q == DONE);
            if (bank_we) begin
                bank_q[elem_q] <= acc_q;
            end
        end
    end

    assign rd_data_o = bank_q[rd_idx_i];
    assign done_o    = done_q;

endmodule

// File: rtl/quad_core_matmul.sv
// Top level: four parallel matmul cores plus a registered address/data result read port.
module quad_core_matmul
    import quad_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       addr_tb,
    output logic [DATA_W-1:0] result,
    output logic              end_process1,
    output logic              end_process2,
    output logic              end_process3,
    output logic              end_process4
);

    logic [DATA_W-1:0]    rd_data [NUM_CORES];
    logic [NUM_CORES-1:0] done;
    logic [DATA_W-1:0]    result_d, result_q;

    for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_core
        matmul_core #(
            .BASE_ROW(g * ROWS_PER_CORE)
        ) u_core (
            .clk      (clk),
            .rst      (rst),
            .rd_idx_i (addr_tb[3:0]),
            .rd_data_o(rd_data[g]),
            .done_o   (done[g])
        );
    end

    // Address = 8r + c, so bits [5:4] name the core and [3:0] its bank entry
    always_comb begin
        result_d = '0;
        if (addr_tb[11:6] == 6'd0) begin
            result_d = rd_data[addr_tb[5:4]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result       = result_q;
    assign end_process1 = done[0];
    assign end_process2 = done[1];
    assign end_process3 = done[2];
    assign end_process4 = done[3];

endmodule

// File: tb/tb_quad_core_matmul.sv
// Self-checking bench for quad_core_matmul: done timing, result sweep, mid-run reset, read port.
module tb_quad_core_matmul;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr_tb;
    logic [11:0] result;
    logic        end_process1, end_process2, end_process3, end_process4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] addr;
        logic [11:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    quad_core_matmul u_dut (
        .clk         (clk),
        .rst         (rst),
        .addr_tb     (addr_tb),
        .result      (result),
        .end_process1(end_process1),
        .end_process2(end_process2),
        .end_process3(end_process3),
        .end_process4(end_process4)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {end_process4, end_process3, end_process2, end_process1};
    endfunction

    // Closed form of C[r][c] mod 4096; out-of-range addresses read as zero
    function automatic logic [11:0] c_model(input logic [11:0] addr);
        int r, c, v;
        if (addr >= 12'd64) return 12'd0;
        r = int'(addr[5:3]);
        c = int'(addr[2:0]);
        v = (224 * r + 64 * r * c + 28 * c + 140) % 4096;
        return 12'(v);
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one read address, push its expectation, then compare after the read latency
    task automatic read_check(input string tag, input logic [11:0] addr, input logic [11:0] exp);
        sb_entry_t e;
        addr_tb = addr;
        sb_q.push_back('{addr: addr, exp: exp});
        tick();
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 12'd1, 12'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq($sformatf("%s_a%0d", tag, e.addr), result, e.exp);
        end
    endtask

    // Count edges from release and check the flag rise lands exactly on edge 146
    task automatic run_to_done(input string tag, input bit disturb);
        logic [3:0] f;
        for (int e = 1; e <= 146; e++) begin
            if (disturb) begin
                addr_tb = 12'($urandom_range(0, 4095));
            end
            if (e == 50) begin
                read_check({tag, "_early0"}, 12'd0, 12'd140);
            end else if (e == 51) begin
                read_check({tag, "_early15"}, 12'd15, 12'd0);
            end else begin
                tick();
            end
            f = flags();
            if (e == 145 || e == 146 || (e % 16) == 0) begin
                check_eq($sformatf("%s_flags_e%0d", tag, e), {8'd0, f},
                         (e >= 146) ? 12'hF : 12'h0);
            end
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) begin
            read_check(tag, 12'(a), c_model(12'(a)));
        end
    endtask

    initial begin
        bit hold_ok;
        rst     = 1'b1;
        addr_tb = 12'd0;
        repeat (3) tick();
        check_eq("reset_result", result, 12'd0);
        check_eq("reset_flags", {8'd0, flags()}, 12'd0);

        // First run with the read address thrashing every cycle
        rst = 1'b0;
        run_to_done("run1", 1'b1);

        read_check("spot", 12'd0, 12'd140);
        read_check("spot", 12'd1, 12'd168);
        read_check("spot", 12'd8, 12'd364);
        read_check("spot", 12'd29, 12'd1912);
        read_check("spot", 12'd63, 12'd944);
        read_check("oor", 12'd64, 12'd0);
        read_check("oor", 12'd4095, 12'd0);
        sweep("sweep1");

        hold_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            addr_tb = 12'($urandom_range(0, 4095));
            tick();
            if (flags() !== 4'hF) hold_ok = 1'b0;
        end
        check_eq("flags_hold_1000", {11'd0, hold_ok}, 12'd1);

        // Mid-computation reset: restart, check async clear, then a clean second run
        rst = 1'b1;
        repeat (3) tick();
        rst     = 1'b0;
        addr_tb = 12'd0;
        repeat (80) tick();
        check_eq("pre_rst_result", result, 12'd140);
        rst = 1'b1;
        #1;
        check_eq("async_rst_result", result, 12'd0);
        check_eq("async_rst_flags", {8'd0, flags()}, 12'd0);
        repeat (3) tick();
        rst = 1'b0;
        run_to_done("run2", 1'b0);
        sweep("sweep2");

        if (sb_q.size() != 0) begin
            check_eq("sb_leftover", 12'(sb_q.size()), 12'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
